// File: rtl/time_set_controller.sv
// Button-driven editor for the clock time registers: capture, edit h/m/s, commit with a one-cycle load.
// Optional auto-repeat of held op1/op2 buttons is enabled by defining AUTO_REPEAT_EN.
module time_set_controller #(
   parameter int unsigned BLINK_DIV    = 25000000,
   parameter int unsigned REPEAT_DELAY = 25000000,
   parameter int unsigned REPEAT_RATE  = 5000000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       set,
   input  logic       op1,
   input  logic       op2,
   input  logic [4:0] cur_hours,
   input  logic [5:0] cur_minutes,
   input  logic [5:0] cur_seconds,
   output logic       load,
   output logic [4:0] new_hours,
   output logic [5:0] new_minutes,
   output logic [5:0] new_seconds,
   output logic       new_is_pm,
   output logic       editing,
   output logic [1:0] field_sel,
   output logic       blink
);

   typedef enum logic [2:0] {IDLE, EDIT_HOUR, EDIT_MIN, EDIT_SEC, COMMIT} state_t;

   localparam int unsigned BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

   if (BLINK_DIV == 0 || REPEAT_DELAY == 0 || REPEAT_RATE == 0) begin : g_bad_cfg
      $error("time_set_controller: BLINK_DIV, REPEAT_DELAY and REPEAT_RATE must be non-zero");
   end

   state_t          state, state_nxt;
   logic            set_q, op1_q, op2_q;
   logic            set_ev, op1_ev, op2_ev;
   logic            rpt_step;
   logic            inc, dec;
   logic [BW-1:0]   blink_cnt;

   function automatic logic [5:0] wrap_step(input logic [5:0] v, input logic [5:0] top,
                                            input logic up);
      if (up) return (v == top) ? 6'd0 : v + 6'd1;
      else    return (v == 6'd0) ? top : v - 6'd1;
   endfunction

   assign set_ev = set & ~set_q;
   assign op1_ev = op1 & ~op1_q;
   assign op2_ev = op2 & ~op2_q;

`ifdef AUTO_REPEAT_EN
   logic [31:0] rpt_cnt;
   logic        rpt_armed;
   logic        hold_ok;

   // The press cycle itself changes a level, so counting starts on the first steady-hold cycle.
   assign hold_ok = editing & (op1 ^ op2) & (op1 == op1_q) & (op2 == op2_q) & ~set_ev;

   always_comb begin
      rpt_step = 1'b0;
      if (hold_ok)
         rpt_step = rpt_armed ? (rpt_cnt == 32'(REPEAT_RATE - 1))
                              : (rpt_cnt == 32'(REPEAT_DELAY - 1));
   end

   always_ff @(posedge clk) begin
      if (reset || !hold_ok) begin
         rpt_cnt   <= '0;
         rpt_armed <= 1'b0;
      end else if (rpt_step) begin
         rpt_cnt   <= '0;
         rpt_armed <= 1'b1;
      end else begin
         rpt_cnt   <= rpt_cnt + 32'd1;
      end
   end
`else
   assign rpt_step = 1'b0;
`endif

   assign inc = editing & ~set_ev & ((op1_ev & ~op2_ev) | (rpt_step & op1));
   assign dec = editing & ~set_ev & ((op2_ev & ~op1_ev) | (rpt_step & op2));

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         set_q <= 1'b1;
         op1_q <= 1'b1;
         op2_q <= 1'b1;
      end else begin
         state <= state_nxt;
         set_q <= set;
         op1_q <= op1;
         op2_q <= op2;
      end
   end

   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      editing   = 1'b0;
      field_sel = 2'd0;
      case (state)
         IDLE:      if (set_ev) state_nxt = EDIT_HOUR;
         EDIT_HOUR: begin
            editing   = 1'b1;
            field_sel = 2'd1;
            if (set_ev) state_nxt = EDIT_MIN;
         end
         EDIT_MIN: begin
            editing   = 1'b1;
            field_sel = 2'd2;
            if (set_ev) state_nxt = EDIT_SEC;
         end
         EDIT_SEC: begin
            editing   = 1'b1;
            field_sel = 2'd3;
            if (set_ev) state_nxt = COMMIT;
         end
         COMMIT: begin
            load      = 1'b1;
            state_nxt = IDLE;
         end
         default:   state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         new_hours   <= '0;
         new_minutes <= '0;
         new_seconds <= '0;
      end else if (state == IDLE && set_ev) begin
         new_hours   <= cur_hours;
         new_minutes <= cur_minutes;
         new_seconds <= cur_seconds;
      end else if (inc || dec) begin
         case (state)
            EDIT_HOUR: new_hours   <= 5'(wrap_step({1'b0, new_hours}, 6'd23, inc));
            EDIT_MIN:  new_minutes <= wrap_step(new_minutes, 6'd59, inc);
            EDIT_SEC:  new_seconds <= wrap_step(new_seconds, 6'd59, inc);
            default:   ;
         endcase
      end
   end

   assign new_is_pm = (new_hours >= 5'd12);

   // Any button activity restarts the blink phase so the edited value is shown immediately.
   always_ff @(posedge clk) begin
      if (reset || !editing || set_ev || op1_ev || op2_ev || rpt_step) begin
         blink_cnt <= '0;
         blink     <= 1'b0;
      end else if (blink_cnt == BW'(BLINK_DIV - 1)) begin
         blink_cnt <= '0;
         blink     <= ~blink;
      end else begin
         blink_cnt <= blink_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_time_set_controller.sv
// Table-driven, scoreboard-checked bench for time_set_controller with BLINK_DIV = 4.
module tb_time_set_controller;

   logic       clk = 1'b0;
   logic       reset, set, op1, op2;
   logic [4:0] cur_hours;
   logic [5:0] cur_minutes, cur_seconds;
   logic       load, new_is_pm, editing, blink;
   logic [4:0] new_hours;
   logic [5:0] new_minutes, new_seconds;
   logic [1:0] field_sel;

   time_set_controller #(.BLINK_DIV(4), .REPEAT_DELAY(8), .REPEAT_RATE(3)) dut (
      .clk(clk), .reset(reset), .set(set), .op1(op1), .op2(op2),
      .cur_hours(cur_hours), .cur_minutes(cur_minutes), .cur_seconds(cur_seconds),
      .load(load), .new_hours(new_hours), .new_minutes(new_minutes),
      .new_seconds(new_seconds), .new_is_pm(new_is_pm), .editing(editing),
      .field_sel(field_sel), .blink(blink)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       load, editing;
      logic [1:0] fs;
      logic [4:0] h;
      logic [5:0] m, s;
      logic       pm, blink, chk_blink;
   } exp_t;

   typedef struct {
      logic       set, op1, op2;
      logic [4:0] ch;
      logic [5:0] cm, cs;
      exp_t       e;
   } vec_t;

   vec_t vecs[$];
   exp_t sb[$];
   int   tests = 0;
   int   failed = 0;

   logic       x_ed;
   logic [1:0] x_fs;
   logic [4:0] x_h, t_ch;
   logic [5:0] x_m, x_s, t_cm, t_cs;

   function automatic exp_t mk(input logic ld, input logic ed, input logic [1:0] fs,
                               input logic [4:0] h, input logic [5:0] m, input logic [5:0] s,
                               input logic bl, input logic chk);
      exp_t e;
      e.load = ld; e.editing = ed; e.fs = fs; e.h = h; e.m = m; e.s = s;
      e.pm = (h >= 5'd12); e.blink = bl; e.chk_blink = chk;
      return e;
   endfunction

   task automatic add(input logic s, input logic o1, input logic o2, input logic ld);
      vec_t v;
      v.set = s; v.op1 = o1; v.op2 = o2;
      v.ch = t_ch; v.cm = t_cm; v.cs = t_cs;
      v.e = mk(ld, x_ed, x_fs, x_h, x_m, x_s, 1'b0, 1'b0);
      vecs.push_back(v);
   endtask

   task automatic idle_row();
      add(1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic cmp(input string nm, input int act, input int exp_v);
      tests++;
      if (act != exp_v) begin
         failed++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp_v);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag);
      exp_t e;
      if (sb.size() == 0) begin
         tests++;
         failed++;
         $display("FAIL %s: scoreboard empty, got nothing, expected an entry", tag);
         return;
      end
      e = sb.pop_front();
      cmp({tag, ".load"},      int'(load),        int'(e.load));
      cmp({tag, ".editing"},   int'(editing),     int'(e.editing));
      cmp({tag, ".field_sel"}, int'(field_sel),   int'(e.fs));
      cmp({tag, ".hours"},     int'(new_hours),   int'(e.h));
      cmp({tag, ".minutes"},   int'(new_minutes), int'(e.m));
      cmp({tag, ".seconds"},   int'(new_seconds), int'(e.s));
      cmp({tag, ".is_pm"},     int'(new_is_pm),   int'(e.pm));
      if (e.chk_blink) cmp({tag, ".blink"}, int'(blink), int'(e.blink));
   endtask

   initial begin
      reset = 1'b1; set = 1'b1; op1 = 1'b0; op2 = 1'b0;
      cur_hours = 5'd13; cur_minutes = 6'd45; cur_seconds = 6'd30;

      // Reset with set held, then keep set held: no edge may be seen.
      for (int i = 0; i < 3; i++) begin
         sb.push_back(mk(1'b0, 1'b0, 2'd0, 5'd0, 6'd0, 6'd0, 1'b0, 1'b1));
         tick();
         check($sformatf("reset%0d", i));
      end
      reset = 1'b0;
      for (int i = 0; i < 10; i++) begin
         sb.push_back(mk(1'b0, 1'b0, 2'd0, 5'd0, 6'd0, 6'd0, 1'b0, 1'b1));
         tick();
         check($sformatf("held_set%0d", i));
      end

      // Sequence A: hour/minute wraps, simultaneous events, commit of 0:59:30.
      t_ch = 5'd13; t_cm = 6'd45; t_cs = 6'd30;
      x_ed = 1'b0; x_fs = 2'd0; x_h = 5'd0; x_m = 6'd0; x_s = 6'd0;
      idle_row();
      x_ed = 1'b1; x_fs = 2'd1; x_h = 5'd13; x_m = 6'd45; x_s = 6'd30;
      add(1'b1, 1'b0, 1'b0, 1'b0); idle_row();
      for (int k = 14; k <= 23; k++) begin
         x_h = 5'(k); add(1'b0, 1'b1, 1'b0, 1'b0); idle_row();
      end
      x_h = 5'd0;  add(1'b0, 1'b1, 1'b0, 1'b0); idle_row();
      x_fs = 2'd2; add(1'b1, 1'b0, 1'b0, 1'b0); idle_row();
      for (int k = 46; k <= 59; k++) begin
         x_m = 6'(k); add(1'b0, 1'b1, 1'b0, 1'b0); idle_row();
      end
      x_m = 6'd0;  add(1'b0, 1'b1, 1'b0, 1'b0); idle_row();
      x_m = 6'd59; add(1'b0, 1'b0, 1'b1, 1'b0); idle_row();
      x_fs = 2'd3; add(1'b1, 1'b1, 1'b0, 1'b0); idle_row();
      add(1'b0, 1'b1, 1'b1, 1'b0); idle_row();
      x_s = 6'd31; add(1'b0, 1'b1, 1'b0, 1'b0); idle_row();
      x_s = 6'd30; add(1'b0, 1'b0, 1'b1, 1'b0); idle_row();
      x_ed = 1'b0; x_fs = 2'd0;
      add(1'b1, 1'b0, 1'b0, 1'b1); idle_row();
      add(1'b0, 1'b1, 1'b0, 1'b0); idle_row();
      add(1'b0, 1'b0, 1'b1, 1'b0); idle_row();

      // Sequence B: 13:45:30 edited to 15:44:30.
      x_ed = 1'b1; x_fs = 2'd1; x_h = 5'd13; x_m = 6'd45; x_s = 6'd30;
      add(1'b1, 1'b0, 1'b0, 1'b0); idle_row();
      x_h = 5'd14; add(1'b0, 1'b1, 1'b0, 1'b0); idle_row();
      x_h = 5'd15; add(1'b0, 1'b1, 1'b0, 1'b0); idle_row();
      x_fs = 2'd2; add(1'b1, 1'b0, 1'b0, 1'b0); idle_row();
      x_m = 6'd44; add(1'b0, 1'b0, 1'b1, 1'b0); idle_row();
      x_fs = 2'd3; add(1'b1, 1'b0, 1'b0, 1'b0); idle_row();
      x_ed = 1'b0; x_fs = 2'd0;
      add(1'b1, 1'b0, 1'b0, 1'b1); idle_row(); idle_row();

      // Sequence C: fresh capture of a morning time.
      t_ch = 5'd7; t_cm = 6'd5; t_cs = 6'd9;
      x_ed = 1'b1; x_fs = 2'd1; x_h = 5'd7; x_m = 6'd5; x_s = 6'd9;
      add(1'b1, 1'b0, 1'b0, 1'b0); idle_row();
      x_h = 5'd6;  add(1'b0, 1'b0, 1'b1, 1'b0); idle_row();
      x_fs = 2'd2; add(1'b1, 1'b0, 1'b0, 1'b0); idle_row();
      x_fs = 2'd3; add(1'b1, 1'b0, 1'b0, 1'b0); idle_row();
      x_ed = 1'b0; x_fs = 2'd0;
      add(1'b1, 1'b0, 1'b0, 1'b1); idle_row();

      for (int i = 0; i < vecs.size(); i++) begin
         set = vecs[i].set; op1 = vecs[i].op1; op2 = vecs[i].op2;
         cur_hours = vecs[i].ch; cur_minutes = vecs[i].cm; cur_seconds = vecs[i].cs;
         sb.push_back(vecs[i].e);
         tick();
         check($sformatf("vec%0d", i));
      end

      // Blink: toggles every 4 edit cycles; an op1 event forces 0 and restarts the count.
      cur_hours = 5'd10; cur_minutes = 6'd20; cur_seconds = 6'd40;
      set = 1'b1;
      sb.push_back(mk(1'b0, 1'b1, 2'd1, 5'd10, 6'd20, 6'd40, 1'b0, 1'b1));
      tick(); check("blink_enter");
      set = 1'b0;
      for (int i = 1; i <= 10; i++) begin
         op1 = (i == 6);
         sb.push_back(mk(1'b0, 1'b1, 2'd1, (i >= 6) ? 5'd11 : 5'd10, 6'd20, 6'd40,
                         (i == 4 || i == 5 || i == 10), 1'b1));
         tick(); check($sformatf("blink%0d", i));
      end
      op1 = 1'b0;
      set = 1'b1;
      sb.push_back(mk(1'b0, 1'b1, 2'd2, 5'd11, 6'd20, 6'd40, 1'b0, 1'b1));
      tick(); check("blink_to_min");
      set = 1'b0;
      sb.push_back(mk(1'b0, 1'b1, 2'd2, 5'd11, 6'd20, 6'd40, 1'b0, 1'b1));
      tick(); check("min_hold");
      set = 1'b1;
      sb.push_back(mk(1'b0, 1'b1, 2'd3, 5'd11, 6'd20, 6'd40, 1'b0, 1'b1));
      tick(); check("to_sec");
      set = 1'b0;
      sb.push_back(mk(1'b0, 1'b1, 2'd3, 5'd11, 6'd20, 6'd40, 1'b0, 1'b1));
      tick(); check("sec_hold");

      // Reset mid-edit aborts with no load and cleared fields.
      reset = 1'b1;
      sb.push_back(mk(1'b0, 1'b0, 2'd0, 5'd0, 6'd0, 6'd0, 1'b0, 1'b1));
      tick(); check("abort_reset");
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         sb.push_back(mk(1'b0, 1'b0, 2'd0, 5'd0, 6'd0, 6'd0, 1'b0, 1'b1));
         tick(); check($sformatf("after_abort%0d", i));
      end

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
